// File: rtl/mdbrot_scheduler_if.sv
// Signal bundle between the frame scheduler, its escape-time engines and the VGA plot port.
// The master modport is the scheduler's view; the slave modport is the engine/VGA side.
interface mdbrot_scheduler_if #(
  parameter int NUM_ENG = 4
);
  logic                  start;
  logic [12:0]           max_iter;
  logic [7:0]            job_x;
  logic [6:0]            job_y;
  logic [12:0]           job_max;
  logic [NUM_ENG-1:0]    job_valid;
  logic [NUM_ENG-1:0]    res_valid;
  logic [13*NUM_ENG-1:0] res_iter;
  logic [NUM_ENG-1:0]    res_ack;
  logic [7:0]            vga_x;
  logic [6:0]            vga_y;
  logic [2:0]            vga_colour;
  logic                  vga_plot;
  logic                  busy;
  logic                  done;

  modport master (
    input  start, max_iter, res_valid, res_iter,
    output job_x, job_y, job_max, job_valid, res_ack,
           vga_x, vga_y, vga_colour, vga_plot, busy, done
  );

  modport slave (
    output start, max_iter, res_valid, res_iter,
    input  job_x, job_y, job_max, job_valid, res_ack,
           vga_x, vga_y, vga_colour, vga_plot, busy, done
  );
endinterface

// File: rtl/mdbrot_scheduler.sv
// Frame scheduler: hands raster pixels to the lowest idle engine and plots results in
// round-robin order, one dispatch and one grant per cycle at most.
module mdbrot_scheduler #(
  parameter int NUM_ENG = 4
) (
  input  logic               clk,
  input  logic               rst,
  mdbrot_scheduler_if.master bus
);
  localparam int         IDX_W  = $clog2(NUM_ENG);
  localparam int         ITER_W = 13;
  localparam logic [7:0] X_LAST = 8'd159;
  localparam logic [6:0] Y_LAST = 7'd119;

  typedef enum logic [1:0] { IDLE, RUN, DRAIN, DONE } state_e;
  typedef logic [IDX_W-1:0]   idx_t;
  typedef logic [NUM_ENG-1:0] eng_vec_t;

  localparam eng_vec_t ONE = eng_vec_t'(1);

  state_e      state_q;
  logic [7:0]  x_q;
  logic [6:0]  y_q;
  eng_vec_t    eng_busy_q, eng_busy_d;
  logic [7:0]  tag_x_q [NUM_ENG];
  logic [6:0]  tag_y_q [NUM_ENG];
  idx_t        rr_q, rr_d;

  logic [12:0] job_max_q;
  logic [7:0]  job_x_q;
  logic [6:0]  job_y_q;
  eng_vec_t    job_valid_q;
  logic [7:0]  vga_x_q;
  logic [6:0]  vga_y_q;
  logic [2:0]  vga_colour_q;
  logic        vga_plot_q;
  logic        busy_q;
  logic        done_q;

  eng_vec_t    eligible, grant_oh, disp_oh;
  logic        grant_found, disp_found, disp_en;
  idx_t        grant_idx, disp_idx, cand;
  logic [ITER_W-1:0] grant_iter;
  logic [2:0]  grant_colour;

  // A result counts only while its engine still owns a pixel; stray strobes are ignored.
  assign eligible = bus.res_valid & eng_busy_q;

  // NOTE: every signal written in a combinational block gets a default first, so no path
  // through the loop leaves it unassigned and infers a latch.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int k = 0; k < NUM_ENG; k++) begin
      cand = idx_t'((int'(rr_q) + k) % NUM_ENG);
      if (!grant_found && eligible[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  always_comb begin
    disp_found = 1'b0;
    disp_idx   = '0;
    for (int i = 0; i < NUM_ENG; i++) begin
      if (!disp_found && !eng_busy_q[i]) begin
        disp_found = 1'b1;
        disp_idx   = idx_t'(i);
      end
    end
  end

  // Dispatch looks at the pre-grant busy flags, so a freed engine waits one cycle.
  assign disp_en      = (state_q == RUN) && disp_found;
  assign grant_oh     = grant_found ? (ONE << grant_idx) : '0;
  assign disp_oh      = disp_en ? (ONE << disp_idx) : '0;
  assign eng_busy_d   = (eng_busy_q & ~grant_oh) | disp_oh;
  assign rr_d         = !grant_found                       ? rr_q :
                        (grant_idx == idx_t'(NUM_ENG - 1)) ? '0   :
                                                             idx_t'(grant_idx + 1'b1);
  assign grant_iter   = bus.res_iter[ITER_W*int'(grant_idx) +: ITER_W];
  assign grant_colour = (grant_iter == job_max_q) ? 3'd0 : grant_iter[2:0];

  assign bus.res_ack    = rst ? grant_oh : '0;
  assign bus.job_x      = job_x_q;
  assign bus.job_y      = job_y_q;
  assign bus.job_max    = job_max_q;
  assign bus.job_valid  = job_valid_q;
  assign bus.vga_x      = vga_x_q;
  assign bus.vga_y      = vga_y_q;
  assign bus.vga_colour = vga_colour_q;
  assign bus.vga_plot   = vga_plot_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples the
  // values from before the edge, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= IDLE;
      x_q          <= '0;
      y_q          <= '0;
      eng_busy_q   <= '0;
      rr_q         <= '0;
      job_max_q    <= '0;
      job_x_q      <= '0;
      job_y_q      <= '0;
      job_valid_q  <= '0;
      vga_x_q      <= '0;
      vga_y_q      <= '0;
      vga_colour_q <= '0;
      vga_plot_q   <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      // NOTE: the tag array is a handful of flops, not a RAM, so it is reset with the rest.
      for (int i = 0; i < NUM_ENG; i++) begin
        tag_x_q[i] <= '0;
        tag_y_q[i] <= '0;
      end
    end else begin
      eng_busy_q   <= eng_busy_d;
      rr_q         <= rr_d;
      job_valid_q  <= disp_oh;
      done_q       <= 1'b0;
      vga_plot_q   <= grant_found;
      vga_x_q      <= grant_found ? tag_x_q[grant_idx] : '0;
      vga_y_q      <= grant_found ? tag_y_q[grant_idx] : '0;
      vga_colour_q <= grant_found ? grant_colour : '0;

      case (state_q)
        IDLE: begin
          if (bus.start) begin
            state_q   <= RUN;
            busy_q    <= 1'b1;
            job_max_q <= bus.max_iter;
            x_q       <= '0;
            y_q       <= '0;
          end
        end
        RUN: begin
          if (disp_en) begin
            job_x_q           <= x_q;
            job_y_q           <= y_q;
            tag_x_q[disp_idx] <= x_q;
            tag_y_q[disp_idx] <= y_q;
            if (x_q == X_LAST) begin
              x_q <= '0;
              if (y_q == Y_LAST) state_q <= DRAIN;
              else               y_q     <= y_q + 7'd1;
            end else begin
              x_q <= x_q + 8'd1;
            end
          end
        end
        DRAIN: begin
          // The last grant's plot was registered on the edge that cleared its busy flag.
          if (eng_busy_q == '0) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mdbrot_scheduler.sv
// Randomised bench for mdbrot_scheduler: engine models with random latency and iteration
// counts feed a raster/colour/round-robin reference kept as plain counters and arrays.
module tb_mdbrot_scheduler;
  localparam int NUM_ENG = 4;
  localparam int NPIX    = 160 * 120;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mdbrot_scheduler_if #(.NUM_ENG(NUM_ENG)) bus ();
  mdbrot_scheduler #(.NUM_ENG(NUM_ENG)) dut (.clk(clk), .rst(rst), .bus(bus));

  int errors = 0;
  int checks = 0;

  // Engine-side model state
  bit                    gate = 1'b0;
  bit                    spur = 1'b0;
  int                    lat_min = 3, lat_max = 3;
  int                    frame_max = 0;
  logic [NUM_ENG-1:0]    m_valid = '0;
  logic [13*NUM_ENG-1:0] m_iter_flat = '0;
  bit                    m_out [NUM_ENG];
  int                    m_cnt [NUM_ENG];
  int                    m_x [NUM_ENG];
  int                    m_y [NUM_ENG];
  int                    rr_ptr = 0;
  logic [NUM_ENG-1:0]    pend_ack = '0;
  int                    nx, ny, disp_count, plot_count, done_count;
  bit                    plotted [160][120];

  assign bus.res_valid = spur ? '1 : m_valid;
  assign bus.res_iter  = spur ? {NUM_ENG{13'h0AB}} : m_iter_flat;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int onehot_idx(input logic [NUM_ENG-1:0] v);
    for (int i = 0; i < NUM_ENG; i++) if (v[i]) return i;
    return 0;
  endfunction

  function automatic logic [2:0] exp_colour(input int iter, input int mx);
    return (iter == mx) ? 3'd0 : 3'(iter % 8);
  endfunction

  task automatic check_all_zero(input string pfx);
    check({pfx, "_job_x"},      bus.job_x,      0);
    check({pfx, "_job_y"},      bus.job_y,      0);
    check({pfx, "_job_max"},    bus.job_max,    0);
    check({pfx, "_job_valid"},  bus.job_valid,  0);
    check({pfx, "_res_ack"},    bus.res_ack,    0);
    check({pfx, "_vga_x"},      bus.vga_x,      0);
    check({pfx, "_vga_y"},      bus.vga_y,      0);
    check({pfx, "_vga_colour"}, bus.vga_colour, 0);
    check({pfx, "_vga_plot"},   bus.vga_plot,   0);
    check({pfx, "_busy"},       bus.busy,       0);
    check({pfx, "_done"},       bus.done,       0);
  endtask

  task automatic new_frame(input int mx, input int lmin, input int lmax);
    frame_max  = mx;
    lat_min    = lmin;
    lat_max    = lmax;
    nx         = 0;
    ny         = 0;
    disp_count = 0;
    plot_count = 0;
    done_count = 0;
    for (int x = 0; x < 160; x++)
      for (int y = 0; y < 120; y++) plotted[x][y] = 1'b0;
  endtask

  task automatic wait_done(input int limit);
    int n = 0;
    do begin
      @(negedge clk); #3;
      n++;
    end while (bus.done !== 1'b1 && n < limit);
    check("done_within_budget", bus.done, 1);
  endtask

  // Engine model and scoreboard: registered outputs are judged at the falling edge,
  // then the pending grant is predicted once the model's res_valid has settled.
  always @(negedge clk) begin
    int d, lo, it, g;
    bit dval;
    logic [NUM_ENG-1:0] exp_ack;
    if (rst !== 1'b1) begin
      m_valid  = '0;
      pend_ack = '0;
      rr_ptr   = 0;
      for (int i = 0; i < NUM_ENG; i++) begin
        m_out[i] = 1'b0;
        m_cnt[i] = 0;
      end
    end else begin
      dval = 1'b0;
      d    = 0;
      if (bus.job_valid != '0) begin
        lo = -1;
        for (int i = NUM_ENG - 1; i >= 0; i--) if (!m_out[i]) lo = i;
        check("disp_onehot", 32'($onehot(bus.job_valid)), 1);
        check("disp_lowest_idle", bus.job_valid, (lo >= 0) ? (1 << lo) : 0);
        check("disp_x", bus.job_x, nx);
        check("disp_y", bus.job_y, ny);
        check("disp_max", bus.job_max, frame_max);
        d    = onehot_idx(bus.job_valid);
        dval = 1'b1;
      end

      if (pend_ack != '0) begin
        g = onehot_idx(pend_ack);
        check("plot_valid", bus.vga_plot, 1);
        check("plot_x", bus.vga_x, m_x[g]);
        check("plot_y", bus.vga_y, m_y[g]);
        check("plot_colour", bus.vga_colour,
              exp_colour(int'(m_iter_flat[13*g +: 13]), frame_max));
        check("plot_once", plotted[m_x[g]][m_y[g]], 0);
        plotted[m_x[g]][m_y[g]] = 1'b1;
        plot_count++;
        m_out[g]   = 1'b0;
        m_valid[g] = 1'b0;
      end else begin
        check("plot_idle", {bus.vga_plot, bus.vga_x, bus.vga_y, bus.vga_colour}, 0);
      end

      if (dval) begin
        m_out[d] = 1'b1;
        m_x[d]   = nx;
        m_y[d]   = ny;
        m_cnt[d] = int'($urandom_range(lat_max, lat_min));
        it = ($urandom_range(3, 0) == 0) ? frame_max : int'($urandom_range(frame_max, 0));
        m_iter_flat[13*d +: 13] = 13'(it);
        disp_count++;
        if (disp_count > NPIX) check("disp_beyond_frame", disp_count, NPIX);
        if (nx == 159) begin
          nx = 0;
          ny++;
        end else begin
          nx++;
        end
      end

      for (int i = 0; i < NUM_ENG; i++) begin
        if (m_out[i] && !m_valid[i]) begin
          if (m_cnt[i] > 0) m_cnt[i]--;
          if (m_cnt[i] == 0 && !gate) m_valid[i] = 1'b1;
        end
      end
      if (bus.done === 1'b1) done_count++;
    end

    #1;
    if (rst === 1'b1) begin
      exp_ack = '0;
      for (int k = 0; k < NUM_ENG; k++) begin
        int c;
        c = (rr_ptr + k) % NUM_ENG;
        if (exp_ack == '0 && m_valid[c] && m_out[c]) exp_ack[c] = 1'b1;
      end
      check("ack_round_robin", bus.res_ack, exp_ack);
      if (exp_ack != '0) rr_ptr = (onehot_idx(exp_ack) + 1) % NUM_ENG;
      pend_ack = exp_ack;
    end else begin
      pend_ack = '0;
    end
  end

  initial begin
    int n;
    rst          = 1'b0;
    bus.start    = 1'b0;
    bus.max_iter = '0;
    new_frame(0, 3, 3);
    repeat (2) @(negedge clk);
    #3;
    check_all_zero("reset");
    rst = 1'b1;
    @(negedge clk); #3;
    check("post_reset_idle_disp", bus.job_valid, 0);
    check("post_reset_idle_plot", bus.vga_plot, 0);

    // Frame A: fixed latency, start held high for the whole frame, max_iter changed mid-frame
    new_frame(16, 3, 3);
    bus.max_iter = 13'd16;
    bus.start    = 1'b1;
    @(negedge clk); #3;
    check("run_busy", bus.busy, 1);
    check("run_job_max", bus.job_max, 16);
    check("run_no_disp_yet", bus.job_valid, 0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); #3;
      check("first_disp_valid", bus.job_valid, 1 << k);
      check("first_disp_x", bus.job_x, k);
      check("first_disp_y", bus.job_y, 0);
    end
    bus.max_iter = 13'd5;
    wait_done(40000);
    check("a_done_busy", bus.busy, 0);
    check("a_plots", plot_count, NPIX);
    check("a_dispatches", disp_count, NPIX);
    check("a_job_max_held", bus.job_max, 16);
    @(negedge clk); #3;
    bus.start = 1'b0;
    check("a_done_single", bus.done, 0);
    check("a_idle_busy", bus.busy, 0);
    @(negedge clk); #3;
    check("a_no_restart_busy", bus.busy, 0);
    check("a_no_restart_disp", bus.job_valid, 0);
    check("a_done_count", done_count, 1);

    // Frame B: max_iter=0, random latency, reset pulsed during DRAIN
    new_frame(0, 1, 3);
    bus.max_iter = 13'd0;
    bus.start    = 1'b1;
    @(negedge clk); #3;
    bus.start = 1'b0;
    n = 0;
    while (disp_count < NPIX && n < 40000) begin
      @(negedge clk); #3;
      n++;
    end
    check("b_drain_reached", disp_count, NPIX);
    check("b_drain_busy", bus.busy, 1);
    rst = 1'b0;
    @(negedge clk); #3;
    check_all_zero("drain_reset");
    rst = 1'b1;
    @(negedge clk); #3;
    check("b_post_reset_disp", bus.job_valid, 0);
    check("b_post_reset_plot", bus.vga_plot, 0);
    check("b_post_reset_busy", bus.busy, 0);

    // Stray results from idle engines must never be acknowledged or plotted
    spur = 1'b1;
    repeat (3) begin
      @(negedge clk); #3;
      check("spur_no_ack", bus.res_ack, 0);
      check("spur_no_plot", bus.vga_plot, 0);
    end
    spur = 1'b0;

    // Frame C: four results released together, then a full frame with short random latency
    new_frame(1000, 1, 2);
    gate         = 1'b1;
    bus.max_iter = 13'd1000;
    bus.start    = 1'b1;
    @(negedge clk); #3;
    bus.start = 1'b0;
    n = 0;
    while (!(m_out[0] && m_out[1] && m_out[2] && m_out[3] &&
             m_cnt[0] == 0 && m_cnt[1] == 0 && m_cnt[2] == 0 && m_cnt[3] == 0) && n < 50) begin
      @(negedge clk); #3;
      n++;
    end
    check("c_all_engines_loaded", {m_out[0], m_out[1], m_out[2], m_out[3]}, 4'b1111);
    gate = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); #3;
      check("c_simultaneous_ack_order", bus.res_ack, 1 << k);
    end
    wait_done(40000);
    check("c_plots", plot_count, NPIX);
    check("c_dispatches", disp_count, NPIX);
    @(negedge clk); #3;
    check("c_done_count", done_count, 1);
    check("c_idle_busy", bus.busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mdbrot_scheduler.md
MDBROT_SCHEDULER -- requirements
Module: mdbrot_scheduler

Interface
REQ-001 Parameter: NUM_ENG, 4, number of escape-time iteration engines served (2..8).
REQ-002 Port: clk  input  1  rising-edge clock for all state.
REQ-003 Port: rst  input  1  reset; synchronous, active-low.
REQ-004 Port: start  input  1  begin one full-frame render; sampled only in IDLE.
REQ-005 Port: max_iter  input  13  escape-iteration limit; latched at frame start.
REQ-006 Port: job_x  output  8  dispatched pixel x coordinate, shared by all engines.
REQ-007 Port: job_y  output  7  dispatched pixel y coordinate, shared by all engines.
REQ-008 Port: job_max  output  13  latched max_iter, driven to all engines.
REQ-009 Port: job_valid  output  NUM_ENG  one-hot dispatch strobe, one cycle.
REQ-010 Port: res_valid  input  NUM_ENG  engine i has a finished result; held until acked.
REQ-011 Port: res_iter  input  13*NUM_ENG  iteration count of engine i in slice [13i+12:13i].
REQ-012 Port: res_ack  output  NUM_ENG  one-hot result acknowledge, one cycle.
REQ-013 Port: vga_x / vga_y / vga_colour / vga_plot  output  8/7/3/1  plot port to the VGA adapter.
REQ-014 Port: busy  output  1  high in RUN and DRAIN.
REQ-015 Port: done  output  1  one-cycle pulse at frame completion.

Function
REQ-016 FSM states: IDLE, RUN, DRAIN, DONE.
REQ-017 IDLE -> RUN on start=1; latch max_iter into job_max; clear pixel counters x=0, y=0.
REQ-018 Raster order: x increments 0..159 first; on x=159, x wraps to 0 and y increments; last pixel (159,119).
REQ-019 Internal flag eng_busy[i] per engine; a pixel tag register (x,y) per engine.
REQ-020 In RUN, each cycle with any eng_busy[i]=0: dispatch the current pixel to the lowest-index idle engine: job_valid[i]=1, job_x/job_y = pixel, tag[i] <= pixel, eng_busy[i] <= 1, advance counter.
REQ-021 Dispatch at most one pixel per cycle; job_x/job_y/job_valid are registered outputs.
REQ-022 After the dispatch of (159,119): RUN -> DRAIN next cycle; no further job_valid.
REQ-023 Result arbitration: round-robin among engines with res_valid[i]=1 AND eng_busy[i]=1; one grant per cycle; after a grant to i, highest priority goes to i+1 (mod NUM_ENG); pointer reset value 0.
REQ-024 On grant to i: res_ack[i]=1 that cycle (combinational from registered state and res_valid), eng_busy[i] <= 0.
REQ-025 res_valid[i] with eng_busy[i]=0 is ignored and never acknowledged.
REQ-026 Plot registered: cycle after the grant, vga_plot=1, vga_x/vga_y = tag[i], vga_colour = 0 if res_iter_i == job_max, otherwise res_iter_i[2:0]; otherwise vga_plot=0 and all vga fields 0.
REQ-027 Dispatch and grant in the same cycle are both permitted; an engine freed by a grant is eligible for dispatch no earlier than the next cycle.
REQ-028 DRAIN -> DONE when all eng_busy=0 and the final plot has been issued; DONE asserts done=1 for one cycle, then -> IDLE.
REQ-029 start is ignored outside IDLE; max_iter changes mid-frame do not affect job_max.
REQ-030 Results may complete in any order; every pixel is plotted exactly once per frame.

Reset
REQ-031 rst=0 at a clock edge: state=IDLE; eng_busy, tags, counters, RR pointer, job_* and vga_* = 0; done=0, busy=0; res_ack=0; this takes effect mid-frame with no drain.
REQ-032 The first clock edge with rst=1 performs no dispatch or plot unless start=1 in IDLE.

Verification
REQ-033 NUM_ENG=4, max_iter=16, engines modelled with fixed 3-cycle latency -> job_valid 0001,0010,0100,1000 on cycles 1-4 carry (0,0),(1,0),(2,0),(3,0); 19200 plots, each pixel once; done pulses once.
REQ-034 All four engines assert res_valid simultaneously -> acks in order 0,1,2,3 on consecutive cycles; next simultaneous set after grant 1 starts at engine 2.
REQ-035 Engine returns iter=16 with max_iter=16 -> vga_colour=0; iter=13 -> vga_colour=5; max_iter=0 with iter=0 -> colour 0.
REQ-036 Engine 2 completes first while engines 0,1,3 are still busy -> plot carries engine 2's tag; next dispatch goes to engine 2 only if no lower index is idle.
REQ-037 rst=0 pulsed during DRAIN -> next cycle all outputs 0, state IDLE; subsequent start renders a full frame correctly.
REQ-038 start held high through RUN and asserted again during DONE -> no restart until IDLE; spurious res_valid on an idle engine -> no ack, no plot.
